// File: rtl/sevseg_pkg.sv
// ============================================================================
// Module      : sevseg_pkg
// Description : Shared types and constants for the sevseg_mux display driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sevseg_pkg;

    localparam int SEG_W = 7;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } slot_state_e;

    // Index n holds the glyph for hex digit n, bit order g..a; b and d are lower case.
    localparam logic [15:0][SEG_W-1:0] HEX_FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [SEG_W-1:0] hex_font(input logic [3:0] nibble);
        return HEX_FONT[nibble];
    endfunction

endpackage

`default_nettype wire

// File: rtl/sevseg_hex7.sv
// ============================================================================
// Module      : sevseg_hex7
// Description : Combinational 4-bit to 7-segment hex decoder (active-high).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sevseg_hex7
    import sevseg_pkg::*;
(
    input  logic [3:0]       nibble_i,
    output logic [SEG_W-1:0] seg_o
);

    assign seg_o = hex_font(nibble_i);

endmodule

`default_nettype wire

// File: rtl/sevseg_mux.sv
// ============================================================================
// Module      : sevseg_mux
// Description : N-digit multiplexed 7-segment driver with double-buffered
//               loads, per-digit hex/raw mode and blank anti-ghost slots.
//               Define SEVSEG_PWM_EN to add the BRIGHT PWM dimming port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sevseg_mux
    import sevseg_pkg::*;
#(
    parameter int DIGITS         = 2,
    parameter int DIGIT_CYCLES   = 12000,
    parameter int BLANK_CYCLES   = 120,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit SEL_ACTIVE_LOW = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [8*DIGITS-1:0] data_i,
    input  logic [DIGITS-1:0]   raw_mode_i,
    input  logic                load_i,
`ifdef SEVSEG_PWM_EN
    input  logic [3:0]          bright_i,
`endif
    output logic [SEG_W-1:0]    seg_o,
    output logic                dp_o,
    output logic [DIGITS-1:0]   sel_o,
    output logic                pending_o,
    output logic                frame_o
);

    localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0]  SLOT_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [SEG_W-1:0]  SEG_OFF   = {SEG_W{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] SEL_OFF   = {DIGITS{SEL_ACTIVE_LOW}};

    logic [CNT_W-1:0]    slot_q, slot_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    slot_state_e         state_q, state_d;

    logic [8*DIGITS-1:0] shadow_data_q, shadow_data_d;
    logic [DIGITS-1:0]   shadow_raw_q, shadow_raw_d;
    logic [8*DIGITS-1:0] active_data_q, active_data_d;
    logic [DIGITS-1:0]   active_raw_q, active_raw_d;
    logic                pending_q, pending_d;

    logic [SEG_W-1:0]    seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    logic                frame_q, frame_d;

    logic                w_slot_wrap;
    logic                w_frame_start;
    logic [7:0]          w_cur_byte;
    logic                w_cur_raw;
    logic [SEG_W-1:0]    w_hex_seg;
    logic [DIGITS-1:0]   w_sel_onehot;
    logic                w_lit;

`ifdef SEVSEG_PWM_EN
    logic [3:0]          shadow_bright_q, shadow_bright_d;
    logic [3:0]          active_bright_q, active_bright_d;
    logic [3:0]          pwm_q, pwm_d;
`endif

    // ---------------- scan counters and slot FSM ----------------
    always_comb begin
        w_slot_wrap   = (slot_q == SLOT_LAST);
        w_frame_start = (slot_q == '0) && (idx_q == '0);
        slot_d        = w_slot_wrap ? '0 : slot_q + CNT_W'(1);
        idx_d         = idx_q;
        if (w_slot_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        state_d = state_q;
        case (state_q)
            ST_BLANK: if (slot_d >= BLANK_END) state_d = ST_ON;
            ST_ON:    if (w_slot_wrap && (BLANK_END != '0)) state_d = ST_BLANK;
            default:  state_d = ST_BLANK;
        endcase
    end

    // ---------------- shadow / active double buffer ----------------
    // A load on the frame-start cycle wins over the commit, deferring it a frame.
    always_comb begin
        shadow_data_d = shadow_data_q;
        shadow_raw_d  = shadow_raw_q;
        active_data_d = active_data_q;
        active_raw_d  = active_raw_q;
        pending_d     = pending_q;
`ifdef SEVSEG_PWM_EN
        shadow_bright_d = shadow_bright_q;
        active_bright_d = active_bright_q;
`endif
        if (load_i) begin
            shadow_data_d = data_i;
            shadow_raw_d  = raw_mode_i;
            pending_d     = 1'b1;
`ifdef SEVSEG_PWM_EN
            shadow_bright_d = bright_i;
`endif
        end else if (w_frame_start && pending_q) begin
            active_data_d = shadow_data_q;
            active_raw_d  = shadow_raw_q;
            pending_d     = 1'b0;
`ifdef SEVSEG_PWM_EN
            active_bright_d = shadow_bright_q;
`endif
        end
    end

    // ---------------- digit mux and output formatting ----------------
    for (genvar d = 0; d < DIGITS; d++) begin : g_sel
        assign w_sel_onehot[d] = (idx_q == IDX_W'(d));
    end

    always_comb begin
        w_cur_byte = '0;
        w_cur_raw  = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (idx_q == IDX_W'(d)) begin
                w_cur_byte = active_data_q[8*d +: 8];
                w_cur_raw  = active_raw_q[d];
            end
        end
    end

    sevseg_hex7 u_hex7 (
        .nibble_i (w_cur_byte[3:0]),
        .seg_o    (w_hex_seg)
    );

`ifdef SEVSEG_PWM_EN
    assign pwm_d = ((state_q != ST_ON) || w_slot_wrap) ? 4'd0 : pwm_q + 4'd1;
    assign w_lit = (state_q == ST_ON) &&
                   ((active_bright_q == 4'hF) || (pwm_q < active_bright_q));
`else
    assign w_lit = (state_q == ST_ON);
`endif

    always_comb begin
        seg_d   = (w_lit ? (w_cur_raw ? w_cur_byte[6:0] : w_hex_seg) : '0) ^ SEG_OFF;
        dp_d    = (w_lit & w_cur_byte[7]) ^ SEG_ACTIVE_LOW;
        sel_d   = ((state_q == ST_ON) ? w_sel_onehot : '0) ^ SEL_OFF;
        frame_d = w_frame_start;
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q        <= '0;
            idx_q         <= '0;
            state_q       <= ST_BLANK;
            shadow_data_q <= '0;
            shadow_raw_q  <= '0;
            active_data_q <= '0;
            active_raw_q  <= '0;
            pending_q     <= 1'b0;
            seg_q         <= SEG_OFF;
            dp_q          <= SEG_ACTIVE_LOW;
            sel_q         <= SEL_OFF;
            frame_q       <= 1'b0;
`ifdef SEVSEG_PWM_EN
            shadow_bright_q <= '0;
            active_bright_q <= '0;
            pwm_q           <= '0;
`endif
        end else begin
            slot_q        <= slot_d;
            idx_q         <= idx_d;
            state_q       <= state_d;
            shadow_data_q <= shadow_data_d;
            shadow_raw_q  <= shadow_raw_d;
            active_data_q <= active_data_d;
            active_raw_q  <= active_raw_d;
            pending_q     <= pending_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            sel_q         <= sel_d;
            frame_q       <= frame_d;
`ifdef SEVSEG_PWM_EN
            shadow_bright_q <= shadow_bright_d;
            active_bright_q <= active_bright_d;
            pwm_q           <= pwm_d;
`endif
        end
    end

    assign seg_o     = seg_q;
    assign dp_o      = dp_q;
    assign sel_o     = sel_q;
    assign pending_o = pending_q;
    assign frame_o   = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_sevseg_mux.sv
// ============================================================================
// Module      : tb_sevseg_mux
// Description : Self-checking bench for sevseg_mux (DIGITS=2, 16-cycle slots).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sevseg_mux;

    localparam int D  = 2;
    localparam int DC = 16;
    localparam int BC = 2;
    localparam int FP = D * DC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data = '0;
    logic [1:0]  raw = '0;
    logic        load = 1'b0;
    logic [3:0]  bright = 4'hF;

    logic [6:0]  seg, seg_n;
    logic        dp, dp_n;
    logic [1:0]  sel, sel_n;
    logic        pending, pending_n;
    logic        frame, frame_n;

    always #5 clk = ~clk;

    sevseg_mux #(.DIGITS(D), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .data_i(data), .raw_mode_i(raw), .load_i(load),
`ifdef SEVSEG_PWM_EN
        .bright_i(bright),
`endif
        .seg_o(seg), .dp_o(dp), .sel_o(sel), .pending_o(pending), .frame_o(frame)
    );

    sevseg_mux #(.DIGITS(D), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC),
                 .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)) u_dut_inv (
        .clk_i(clk), .rst_ni(rst_n), .data_i(data), .raw_mode_i(raw), .load_i(load),
`ifdef SEVSEG_PWM_EN
        .bright_i(bright),
`endif
        .seg_o(seg_n), .dp_o(dp_n), .sel_o(sel_n), .pending_o(pending_n), .frame_o(frame_n)
    );

    typedef struct {
        logic [15:0] data;
        logic [1:0]  raw;
        logic [6:0]  seg0;
        logic        dp0;
        logic [6:0]  seg1;
        logic        dp1;
    } vec_t;

    vec_t vecs[6];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position p counts cycles since reset release.
    int          p = 0;
    logic [15:0] m_sh_data = '0, m_ac_data = '0;
    logic [1:0]  m_sh_raw = '0, m_ac_raw = '0;
    logic [3:0]  m_sh_br = '0, m_ac_br = '0;
    logic        m_pend = 1'b0;
    logic [7:0]  obs0 = '0, obs1 = '0;

    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
            4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
            4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;  default: return 7'b1110001;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (pos %0d)", name, act, exp, p);
        end
    endtask

    task automatic model_reset();
        p = 0; m_sh_data = '0; m_ac_data = '0; m_sh_raw = '0; m_ac_raw = '0;
        m_sh_br = '0; m_ac_br = '0; m_pend = 1'b0;
    endtask

    task automatic step(input logic ld, input logic [15:0] d, input logic [1:0] r,
                        input logic [3:0] b);
        int slot, idx;
        logic [7:0] byt;
        logic lit, edp, ef;
        logic [6:0] es;
        logic [1:0] esel;
        load = ld; data = d; raw = r; bright = b;
        slot = p % DC;
        idx  = (p / DC) % D;
        byt  = m_ac_data[8*idx +: 8];
        lit  = (slot >= BC);
`ifdef SEVSEG_PWM_EN
        lit  = lit && ((m_ac_br == 4'hF) || ((slot - BC) < int'(m_ac_br)));
`endif
        es   = lit ? (m_ac_raw[idx] ? byt[6:0] : font(byt[3:0])) : 7'd0;
        edp  = lit & byt[7];
        esel = (slot >= BC) ? (2'b01 << idx) : 2'b00;
        ef   = ((p % FP) == 0);
        if (ld) begin
            m_sh_data = d; m_sh_raw = r; m_sh_br = b; m_pend = 1'b1;
        end else if (ef && m_pend) begin
            m_ac_data = m_sh_data; m_ac_raw = m_sh_raw; m_ac_br = m_sh_br; m_pend = 1'b0;
        end
        @(posedge clk);
        #1;
        load = 1'b0;
        check("outputs", {seg, dp, sel, frame, pending}, {es, edp, esel, ef, m_pend});
        check("outputs_inv", {seg_n, dp_n, sel_n, frame_n, pending_n},
              {~es, ~edp, ~esel, ef, m_pend});
        if ((p % FP) == 8)  obs0 = {seg, dp};
        if ((p % FP) == 24) obs1 = {seg, dp};
        p++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, data, raw, 4'hF);
    endtask

    task automatic run_to(input int phase);
        while ((p % FP) != phase) step(1'b0, data, raw, 4'hF);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h8A03, 2'b00, 7'b1001111, 1'b0, 7'b1110111, 1'b1};
        vecs[1] = '{16'h0049, 2'b01, 7'b1001001, 1'b0, 7'b0111111, 1'b0};
        vecs[2] = '{16'h0D81, 2'b00, 7'b0000110, 1'b1, 7'b1011110, 1'b0};
        vecs[3] = '{16'hC00F, 2'b10, 7'b1110001, 1'b0, 7'b1000000, 1'b1};
        vecs[4] = '{16'h7F00, 2'b11, 7'b0000000, 1'b0, 7'b1111111, 1'b0};
        vecs[5] = '{16'h058B, 2'b00, 7'b1111100, 1'b1, 7'b1101101, 1'b0};

        // Reset: outputs inactive on both polarities.
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", {seg, dp, sel, frame, pending}, 12'h000);
        check("reset_out_inv", {seg_n, dp_n, sel_n, frame_n, pending_n},
              {7'h7F, 1'b1, 2'b11, 1'b0, 1'b0});
        rst_n = 1'b1;
        model_reset();

        // Scan pattern and frame pulses over two frames with zero data.
        idle(2 * FP + 3);

        // Table of hex/raw patterns, each loaded mid-frame.
        for (int v = 0; v < 6; v++) begin
            run_to(5 + v);
            step(1'b1, vecs[v].data, vecs[v].raw, 4'hF);
            idle(70);
            check("tbl_digit0", obs0, {vecs[v].seg0, vecs[v].dp0});
            check("tbl_digit1", obs1, {vecs[v].seg1, vecs[v].dp1});
        end

        // Double buffering: two loads in one frame, only the second shows.
        run_to(10);
        step(1'b1, vecs[0].data, vecs[0].raw, 4'hF);
        check("db_pend_rise", pending, 1);
        run_to(20);
        step(1'b1, vecs[1].data, vecs[1].raw, 4'hF);
        run_to(0);
        check("db_pend_hold", pending, 1);
        step(1'b0, data, raw, 4'hF);
        check("db_pend_clear", pending, 0);
        run_to(25);
        check("db_digit0", obs0, {vecs[1].seg0, vecs[1].dp0});
        check("db_digit1", obs1, {vecs[1].seg1, vecs[1].dp1});

        // Collision: load on the frame-start cycle defers the commit one frame.
        run_to(0);
        step(1'b1, vecs[2].data, vecs[2].raw, 4'hF);
        check("coll_pend", pending, 1);
        run_to(0);
        check("coll_pend_frame", pending, 1);
        check("coll_old_shown", obs0, {vecs[1].seg0, vecs[1].dp0});
        step(1'b0, data, raw, 4'hF);
        check("coll_commit", pending, 0);
        run_to(9);
        check("coll_new_shown", obs0, {vecs[2].seg0, vecs[2].dp0});

`ifdef SEVSEG_PWM_EN
        // PWM: count lit cycles in digit 0's slot for several brightness values.
        for (int k = 0; k < 3; k++) begin
            logic [3:0] b;
            int lit_cnt;
            b = (k == 0) ? 4'd4 : ((k == 1) ? 4'hF : 4'd0);
            run_to(12);
            step(1'b1, 16'h8888, 2'b00, b);
            run_to(0);
            step(1'b0, data, raw, 4'hF);
            lit_cnt = 0;
            for (int i = 1; i < DC; i++) begin
                step(1'b0, data, raw, 4'hF);
                if (seg != 7'd0) lit_cnt++;
            end
            check("pwm_lit_count", lit_cnt, (b == 4'hF) ? 14 : int'(b));
        end
`endif

        // Randomized loads against the model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 15) == 0), 16'($urandom), 2'($urandom),
                 4'($urandom));
        end

        // Asynchronous reset mid-slot with pending data discarded.
        run_to(10);
        step(1'b1, 16'hFFFF, 2'b11, 4'hF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", {seg, dp, sel, frame, pending}, 12'h000);
        check("async_rst_out_inv", {seg_n, dp_n, sel_n, frame_n, pending_n},
              {7'h7F, 1'b1, 2'b11, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        idle(FP + 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sevseg_mux.md
# sevseg_mux

Parametrised N-digit multiplexed 7-segment display driver for Pmod-style displays on the iCE40 boards. It sits between the com2 UART register interface (or any host logic) and the Pmod pins, and generalises the fixed two-digit raw driver in four ways: any digit count, per-digit hex/raw mode, atomic double-buffered updates with a load handshake, and anti-ghosting blank slots. Optional PWM brightness control is compiled in with a macro.

## Interface
- DIGITS, 2, number of multiplexed digits (≥1)
- DIGIT_CYCLES, 12000, CLK cycles per digit slot (1 kHz per digit at 12 MHz)
- BLANK_CYCLES, 120, leading cycles of each slot with all outputs inactive; must be < DIGIT_CYCLES
- SEG_ACTIVE_LOW, 0, 1 inverts SEG and DP
- SEL_ACTIVE_LOW, 0, 1 inverts SEL
- CLK  in  1  system clock; the block uses one clock
- RST_N  in  1  reset, asynchronous and active-low
- DATA  in  8*DIGITS  byte d = DATA[8d+7:8d]; bit7 = DP; hex mode uses [3:0]; raw mode uses [6:0] as segments g..a
- RAW_MODE  in  DIGITS  bit d: 1 = raw segments, 0 = hex decode
- LOAD  in  1  single-cycle strobe capturing DATA, RAW_MODE (and BRIGHT) into the shadow register
- BRIGHT  in  4  brightness, present only with SEVSEG_PWM_EN
- SEG  out  7  segments, SEG[0]=a … SEG[6]=g
- DP  out  1  decimal point
- SEL  out  DIGITS  one-hot digit select
- PENDING  out  1  shadow holds data not yet shown
- FRAME  out  1  one-cycle pulse at the start of each frame

## Operation
- Slot counter 0..DIGIT_CYCLES-1 and digit index 0..DIGITS-1. The index advances when the slot counter wraps. It wraps from DIGITS-1 to 0.
- Per-slot FSM:
  - BLANK, for slot counts 0..BLANK_CYCLES-1: SEG, DP and SEL are inactive.
  - ON, for the remaining counts: SEL[idx] is active and SEG/DP show the active byte for idx.
  - ON returns to BLANK when the slot counter wraps.
- Hex decode: 0–F uses the standard font, with b and d in lower case.
- Frame start is idx=0 with slot count 0. On that cycle:
  - FRAME pulses.
  - If PENDING=1 and LOAD=0, the shadow is copied to the active register and PENDING clears.
- LOAD captures into the shadow and sets PENDING.
  - LOAD while PENDING=1 overwrites the shadow; the last load wins.
  - LOAD on the frame-start cycle has priority. The shadow takes the new data, PENDING stays 1, and the commit is deferred to the next frame.
- The display never shows a partially loaded frame.

## Timing
- All outputs are registered, with one cycle of latency from the internal counters.
- Reset values:
  - SEG, DP and SEL are inactive (after the polarity parameters are applied).
  - PENDING=0 and FRAME=0.
  - The active and shadow registers are 0, idx=0, slot count=0, and the FSM is in BLANK.
- First FRAME pulse: on the cycle after RST_N deasserts, with the registered output visible one cycle later.
- Frame period is DIGITS*DIGIT_CYCLES. At most one SEL bit is active at any time.
- RST_N asserted mid-slot: outputs go inactive immediately (asynchronously), and any pending data is discarded.

## Configuration
- SEVSEG_PWM_EN defined:
  - The BRIGHT port exists and is latched with the shadow/commit path.
  - A 4-bit PWM counter resets at the start of ON and increments each cycle, wrapping.
  - SEG/DP are lit while pwm_cnt < BRIGHT. BRIGHT=4'hF means always lit; BRIGHT=0 means dark (SEL is still driven).
- SEVSEG_PWM_EN undefined: no BRIGHT port, and segments are lit for the whole ON phase.

## Structure
- Package sevseg_pkg:
  - SEG_W=7.
  - The 16-entry hex font constant table.
  - Segment index constants SEG_A..SEG_G.
- Sub-module sevseg_hex7: combinational 4-bit to 7-segment decoder, instantiated once on the muxed nibble.

## Test plan
Common setup: DIGITS=2, DIGIT_CYCLES=16, BLANK_CYCLES=2.
- **Reset and scan:** RST_N low, then release.
  - Outputs are all 0 during reset.
  - SEL=00 for 2 cycles, then 01 for 14 cycles, 00 for 2, then 10 for 14, repeating.
  - FRAME pulses every 32 cycles.
- **Hex decode:** LOAD with DATA=16'h8A03, RAW_MODE=00.
  - After commit, digit0 gives SEG=7'b1001111 with DP=0.
  - Digit1 gives SEG=7'b1110111 with DP=1.
- **Raw mode:** RAW_MODE=01, DATA[7:0]=8'h49 → digit0 gives SEG=7'b1001001 and DP=0.
- **Double buffering:** LOAD mid-frame.
  - PENDING rises the next cycle.
  - The displayed value is unchanged until FRAME, after which PENDING=0 and the new value shows.
  - A second LOAD before FRAME means only the second value appears.
- **Collision:** LOAD coincident with frame start → PENDING stays 1, the old value is shown for one more frame, and the commit happens on the following FRAME.
- **PWM:** with SEVSEG_PWM_EN, BRIGHT=4 → segments lit for exactly 4 of the 14 ON cycles per slot. BRIGHT=F gives 14 of 14; BRIGHT=0 gives 0.
- **Polarity:** SEG_ACTIVE_LOW=1 → the reset value of SEG is 7'h7F.
